bist_datapath: RTL and testbench
================================

// Module: bist_datapath
// PURPOSE
//  Test-side datapath driven by the BIST controller's init/running/toggle/finish strobes.
//  - An LFSR pattern generator drives the circuit under test (CUT).
//  - A MISR compacts the CUT responses into a signature.
//  - On finish, the signature is compared with a golden value and a pass/fail result is latched.
//  Sits between the controller and the CUT; its done/pass outputs feed top-level status.
// PARAMETERS
//  N       8      width of LFSR, MISR, cut_in, cut_out
//  TAPS    8'hB8  feedback polynomial mask, shared by LFSR and MISR
//  SEED    8'h01  LFSR load value on reset/init; must be nonzero
//  MISR_IV 8'h00  MISR load value on reset/init
//  GOLDEN  8'h00  expected final signature
//  CNT_W   16     width of pattern_count
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-high reset
//  init           in   1      1-cycle strobe: reload seed/MISR, arm the datapath
//  running        in   1      level: advance one pattern per cycle while high
//  toggle         in   1      1-cycle strobe: flip pattern phase (true/complement)
//  finish         in   1      1-cycle strobe: end of test, start compare
//  cut_out        in   N      CUT response, sampled every step
//  cut_in         out  N      pattern to CUT: phase ? ~lfsr : lfsr (combinational from regs)
//  signature      out  N      current MISR contents
//  pattern_count  out  CNT_W  steps taken since init; saturates at all-ones
//  done           out  1      compare complete; held until init/reset
//  pass           out  1      valid when done: signature == GOLDEN
// BEHAVIOUR
//  Reset (async):
//   - lfsr=SEED, misr=MISR_IV, phase=0, pattern_count=0, done=0, pass=0, state=IDLE.
//   - cut_in = SEED.
//  States: IDLE, ARMED, RUN, COMPARE, DONE.
//  Input priority per cycle: init > finish > toggle/running.
//   - init (any state): same register loads as reset, except state goes to ARMED.
//   - ARMED: running=1 -> RUN. The step also executes in this same cycle.
//     finish=1 -> COMPARE, with signature = MISR_IV.
//   - RUN: step on each cycle with running=1; running=0 stalls, all registers hold.
//     finish -> COMPARE. A step requested in the same cycle as finish still executes.
//   - COMPARE (exactly 1 cycle): pass <= (misr == GOLDEN); done <= 1; -> DONE.
//   - DONE: all registers hold; running, toggle and finish are ignored. Only init/reset leave.
//   - IDLE: running, toggle and finish are ignored.
//  Step, one clock:
//   - lfsr <= {lfsr[N-2:0], ^(lfsr & TAPS)}.
//   - misr <= {misr[N-2:0], ^(misr & TAPS)} ^ cut_out, using cut_out sampled this cycle.
//   - pattern_count += 1, unless already all-ones.
//  toggle, in ARMED/RUN only:
//   - phase <= ~phase; cut_in changes the next cycle.
//   - Coincident with a step: the step uses the old phase.
//  Latency: done and pass rise 2 cycles after the finish edge (COMPARE, then DONE).
//  LFSR all-zero is unreachable when SEED != 0. SEED == 0 is a configuration error;
//  simulation must $error on it.
//  Reset mid-test: immediate return to IDLE with reset values; no partial result is retained.
// TESTING
//  1 Reset release -> cut_in=0x01, signature=0x00, done=0, pass=0, pattern_count=0.
//  2 init, then running for 4 cycles, cut_out=0
//    -> cut_in sequence 0x02,0x04,0x08,0x11; pattern_count=4.
//  3 init, 3 steps, then toggle -> cut_in = ~0x08 = 0xF7 next cycle;
//    second toggle restores 0x08.
//  4 Loopback cut_out=cut_in for 20 steps, then finish, with GOLDEN set to the model
//    signature -> done=1 and pass=1 exactly 2 cycles after finish;
//    same run with GOLDEN^1 -> pass=0.
//  5 running=0 for 5 cycles mid-RUN -> lfsr, misr and pattern_count unchanged;
//    finish and running in the same cycle -> final step included in the signature.
//  6 reset asserted mid-RUN -> all outputs at reset values within the same cycle;
//    init in DONE -> done=0, re-armed, cut_in=0x01.

Source files
------------

// File: rtl/bist_datapath_if.sv
// Handshake bundle between the BIST controller, CUT and datapath.
// Strobes and the CUT response flow in; pattern, signature and status flow out.
interface bist_datapath_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             init;
  logic             running;
  logic             toggle;
  logic             finish;
  logic [N-1:0]     cut_out;
  logic [N-1:0]     cut_in;
  logic [N-1:0]     signature;
  logic [CNT_W-1:0] pattern_count;
  logic             done;
  logic             pass;

  modport master (
    output init, running, toggle, finish, cut_out,
    input  cut_in, signature, pattern_count, done, pass
  );

  modport slave (
    input  init, running, toggle, finish, cut_out,
    output cut_in, signature, pattern_count, done, pass
  );
endinterface

// File: rtl/bist_datapath.sv
// BIST datapath: LFSR pattern source, MISR response compactor and
// golden-signature compare, sequenced by controller strobes.
module bist_datapath #(
  parameter int           N       = 8,
  parameter logic [N-1:0] TAPS    = 8'hB8,
  parameter logic [N-1:0] SEED    = 8'h01,
  parameter logic [N-1:0] MISR_IV = 8'h00,
  parameter logic [N-1:0] GOLDEN  = 8'h00,
  parameter int           CNT_W   = 16
) (
  input logic             clk,
  input logic             reset,
  bist_datapath_if.slave  io_bus
);

  if (SEED == '0) begin : g_bad_seed
    $error("bist_datapath: SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_CMP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [N-1:0]     r_lfsr;
  logic [N-1:0]     r_misr;
  logic             r_phase;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_pass;

  logic             w_step;
  logic             w_toggle;
  logic             w_cmp;
  logic [N-1:0]     w_lfsr_nxt;
  logic [N-1:0]     w_misr_nxt;

  assign w_lfsr_nxt = {r_lfsr[N-2:0], ^(r_lfsr & TAPS)};
  assign w_misr_nxt = {r_misr[N-2:0], ^(r_misr & TAPS)}
                    ^ io_bus.cut_out;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: init beats finish, finish beats running.
  always_comb begin
    w_next = r_state;
    if (io_bus.init) begin
      w_next = S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (io_bus.finish)       w_next = S_CMP;
          else if (io_bus.running) w_next = S_RUN;
        end
        S_RUN: begin
          if (io_bus.finish) w_next = S_CMP;
        end
        S_CMP:   w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  // Datapath controls. In ARMED a finish wins over the first step
  // so the signature stays at MISR_IV; in RUN a coincident step
  // still lands before the compare.
  always_comb begin
    w_step   = 1'b0;
    w_toggle = 1'b0;
    w_cmp    = 1'b0;
    if (!io_bus.init) begin
      case (r_state)
        S_ARMED: begin
          w_step   = io_bus.running & ~io_bus.finish;
          w_toggle = io_bus.toggle & ~io_bus.finish;
        end
        S_RUN: begin
          w_step   = io_bus.running;
          w_toggle = io_bus.toggle & ~io_bus.finish;
        end
        S_CMP:   w_cmp = 1'b1;
        default: ;
      endcase
    end
  end

  // Pattern, signature, phase, count and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= SEED;
      r_misr  <= MISR_IV;
      r_phase <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else if (io_bus.init) begin
      r_lfsr  <= SEED;
      r_misr  <= MISR_IV;
      r_phase <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      if (w_step) begin
        r_lfsr <= w_lfsr_nxt;
        r_misr <= w_misr_nxt;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_toggle) r_phase <= ~r_phase;
      if (w_cmp) begin
        r_pass <= (r_misr == GOLDEN);
        r_done <= 1'b1;
      end
    end
  end

  assign io_bus.cut_in        = r_phase ? ~r_lfsr : r_lfsr;
  assign io_bus.signature     = r_misr;
  assign io_bus.pattern_count = r_cnt;
  assign io_bus.done          = r_done;
  assign io_bus.pass          = r_pass;

endmodule

// File: tb/tb_bist_datapath.sv
// Bench for bist_datapath: reference model feeds a scoreboard queue,
// two DUTs differ only in GOLDEN so both pass and fail are seen.
module tb_bist_datapath;

  function automatic logic [7:0] gold_sig(input int n);
    logic [7:0] l, m;
    l = 8'h01;
    m = 8'h00;
    for (int i = 0; i < n; i++) begin
      m = {m[6:0], ^(m & 8'hB8)} ^ l;
      l = {l[6:0], ^(l & 8'hB8)};
    end
    return m;
  endfunction

  localparam logic [7:0] GA = gold_sig(20);
  localparam logic [7:0] GB = GA ^ 8'h01;

  logic clk;
  logic reset;
  logic loop_en;
  logic [7:0] tb_co;

  bist_datapath_if #(.N(8), .CNT_W(16)) bus_a ();
  bist_datapath_if #(.N(8), .CNT_W(16)) bus_b ();

  assign bus_a.cut_out = loop_en ? bus_a.cut_in : tb_co;
  assign bus_b.init    = bus_a.init;
  assign bus_b.running = bus_a.running;
  assign bus_b.toggle  = bus_a.toggle;
  assign bus_b.finish  = bus_a.finish;
  assign bus_b.cut_out = bus_a.cut_out;

  bist_datapath #(.GOLDEN(GA)) u_dut_a (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus_a)
  );

  bist_datapath #(.GOLDEN(GB)) u_dut_b (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  ci;
    logic [7:0]  sig;
    logic [15:0] cnt;
    logic        done;
    logic        pa;
    logic        pb;
  } exp_t;

  exp_t sb[$];

  // reference model; states 0 idle,1 armed,2 run,3 compare,4 done
  int          m_st;
  logic [7:0]  m_lfsr, m_misr;
  logic        m_ph, m_done, m_pa, m_pb;
  logic [15:0] m_cnt;

  function automatic logic [7:0] m_ci();
    return m_ph ? ~m_lfsr : m_lfsr;
  endfunction

  task automatic m_load(input int st);
    m_st   = st;
    m_lfsr = 8'h01;
    m_misr = 8'h00;
    m_ph   = 1'b0;
    m_cnt  = 16'd0;
    m_done = 1'b0;
    m_pa   = 1'b0;
    m_pb   = 1'b0;
  endtask

  task automatic m_step(input logic [7:0] co);
    m_misr = {m_misr[6:0], ^(m_misr & 8'hB8)} ^ co;
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic m_clock(input logic i, r, t, f,
                         input logic [7:0] co);
    logic [7:0] eco;
    eco = loop_en ? m_ci() : co;
    if (i) begin
      m_load(1);
    end else if (m_st == 1) begin
      if (f) m_st = 3;
      else begin
        if (r) begin m_step(eco); m_st = 2; end
        if (t) m_ph = ~m_ph;
      end
    end else if (m_st == 2) begin
      if (r) m_step(eco);
      if (f) m_st = 3;
      else if (t) m_ph = ~m_ph;
    end else if (m_st == 3) begin
      m_pa   = (m_misr == GA);
      m_pb   = (m_misr == GB);
      m_done = 1'b1;
      m_st   = 4;
    end
  endtask

  task automatic cyc(input logic i, r, t, f,
                     input logic [7:0] co);
    exp_t e;
    bus_a.init    = i;
    bus_a.running = r;
    bus_a.toggle  = t;
    bus_a.finish  = f;
    tb_co         = co;
    m_clock(i, r, t, f, co);
    e.ci   = m_ci();
    e.sig  = m_misr;
    e.cnt  = m_cnt;
    e.done = m_done;
    e.pa   = m_pa;
    e.pb   = m_pb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cut_in", 32'(bus_a.cut_in), 32'(e.ci));
    chk("signature", 32'(bus_a.signature), 32'(e.sig));
    chk("count", 32'(bus_a.pattern_count), 32'(e.cnt));
    chk("done", 32'(bus_a.done), 32'(e.done));
    chk("pass_a", 32'(bus_a.pass), 32'(e.pa));
    chk("pass_b", 32'(bus_b.pass), 32'(e.pb));
    chk("done_b", 32'(bus_b.done), 32'(e.done));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ci"}, 32'(bus_a.cut_in), 32'h01);
    chk({tag, "_sig"}, 32'(bus_a.signature), 32'h00);
    chk({tag, "_cnt"}, 32'(bus_a.pattern_count), 32'h0);
    chk({tag, "_done"}, 32'(bus_a.done), 32'h0);
    chk({tag, "_pass"}, 32'(bus_a.pass), 32'h0);
  endtask

  initial begin
    reset         = 1'b1;
    loop_en       = 1'b0;
    tb_co         = 8'h00;
    bus_a.init    = 1'b0;
    bus_a.running = 1'b0;
    bus_a.toggle  = 1'b0;
    bus_a.finish  = 1'b0;
    m_load(0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_vals("t1");

    // idle ignores running/toggle/finish
    cyc(0, 1, 1, 1, 8'h55);

    // plain pattern sequence
    cyc(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, 8'h00);
    chk("t2_ci", 32'(bus_a.cut_in), 32'h11);
    chk("t2_cnt", 32'(bus_a.pattern_count), 32'd4);

    // phase toggle, and toggle coincident with a step
    cyc(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t3_inv", 32'(bus_a.cut_in), 32'hF7);
    cyc(0, 0, 1, 0, 8'h00);
    chk("t3_back", 32'(bus_a.cut_in), 32'h08);
    cyc(0, 1, 1, 0, 8'h3C);
    cyc(0, 1, 0, 0, 8'hC3);

    // loopback run against matching and mismatching golden
    loop_en = 1'b1;
    cyc(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 8'h00);
    chk("t4_sig", 32'(bus_a.signature), 32'(GA));
    cyc(0, 0, 0, 1, 8'h00);
    chk("t4_done1", 32'(bus_a.done), 32'h0);
    cyc(0, 0, 0, 0, 8'h00);
    chk("t4_done2", 32'(bus_a.done), 32'h1);
    chk("t4_pass", 32'(bus_a.pass), 32'h1);
    chk("t4_fail", 32'(bus_b.pass), 32'h0);
    // DONE ignores everything but init
    cyc(0, 1, 1, 1, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    loop_en = 1'b0;

    // stall mid-run, then finish with a final step
    cyc(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++)
      cyc(0, 1, 0, 0, 8'($urandom_range(0, 255)));
    for (int k = 0; k < 5; k++)
      cyc(0, 0, 0, 0, 8'($urandom_range(0, 255)));
    chk("t5_cnt", 32'(bus_a.pattern_count), 32'd3);
    cyc(0, 1, 0, 1, 8'hA5);
    chk("t5_cnt_fin", 32'(bus_a.pattern_count), 32'd4);
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);

    // finish straight from ARMED keeps MISR_IV
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 1, 8'hFF);
    cyc(0, 0, 0, 0, 8'h00);
    chk("t5_armed_sig", 32'(bus_a.signature), 32'h00);

    // reset mid-run takes effect without a clock edge
    cyc(1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 0, 8'h5A);
    reset = 1'b1;
    #1;
    chk_reset_vals("t6_rst");
    m_load(0);
    #1;
    reset = 1'b0;
    cyc(0, 1, 0, 0, 8'h00);

    // init from DONE re-arms
    cyc(1, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h77);
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    chk("t6_done", 32'(bus_a.done), 32'h1);
    cyc(1, 0, 0, 0, 8'h00);
    chk("t6_rearm_done", 32'(bus_a.done), 32'h0);
    chk("t6_rearm_ci", 32'(bus_a.cut_in), 32'h01);
    cyc(0, 1, 0, 0, 8'h00);
    chk("t6_rearm_ci2", 32'(bus_a.cut_in), 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
